execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus an iterative RV M-extension unit.
// A valid/ready handshake sits on both sides; the result bundle is held until taken.
module execute_stage #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [3:0]      alu_control,
   input  logic            md_en,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] pc_address,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_res_out,
   output logic [XLEN-1:0] next_sel_address,
   output logic [XLEN-1:0] branch_target,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SHW-1:0]  r_count;

   // Iteration registers: r_hi/r_lo are product halves or remainder/quotient.
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_mc;
   logic [2:0]      r_op;
   logic            r_neg_a;
   logic            r_neg_res;
   logic            r_div0;
   logic [XLEN-1:0] r_pc4;
   logic [XLEN-1:0] r_pcimm;

   logic            r_out_valid;
   logic [XLEN-1:0] r_res;
   logic [XLEN-1:0] r_npc;
   logic [XLEN-1:0] r_bt;

   logic            w_md_en;
   logic            w_accept;
   logic            w_accept_alu;
   logic            w_accept_md;
   logic            w_fix;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_alu_res;
   logic            w_a_signed;
   logic            w_b_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic [XLEN-1:0] w_mul_add;
   logic [XLEN:0]   w_mul_sum;
   logic [XLEN:0]   w_div_shift;
   logic [XLEN:0]   w_div_diff;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0] w_md_res;

   assign w_md_en      = (ENABLE_M != 0) && md_en;
   assign in_ready     = (r_state == IDLE) && (!r_out_valid || out_ready);
   assign w_accept     = in_valid && in_ready;
   assign w_accept_alu = w_accept && !w_md_en;
   assign w_accept_md  = w_accept && w_md_en;
   assign w_fix        = (r_state == FIX);
   assign busy         = (r_state != IDLE);

   assign out_valid        = r_out_valid;
   assign alu_res_out      = r_res;
   assign next_sel_address = r_npc;
   assign branch_target    = r_bt;

   assign w_shamt = b_i[SHW-1:0];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_alu_res = '0;
      case (alu_control)
         4'd0:    w_alu_res = a_i + b_i;
         4'd1:    w_alu_res = a_i - b_i;
         4'd2:    w_alu_res = a_i << w_shamt;
         4'd3:    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         4'd4:    w_alu_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
         4'd5:    w_alu_res = a_i ^ b_i;
         4'd6:    w_alu_res = a_i >> w_shamt;
         4'd7:    w_alu_res = $signed(a_i) >>> w_shamt;
         4'd8:    w_alu_res = a_i | b_i;
         4'd9:    w_alu_res = a_i & b_i;
         4'd10:   w_alu_res = b_i;
         default: w_alu_res = '0;
      endcase
   end

   // Signed operands: MULH/MULHSU/DIV/REM take a signed a; MULH/DIV/REM a signed b.
   assign w_a_signed = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
   assign w_b_signed = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
   assign w_a_neg    = w_a_signed && a_i[XLEN-1];
   assign w_b_neg    = w_b_signed && b_i[XLEN-1];
   assign w_a_mag    = w_a_neg ? -a_i : a_i;
   assign w_b_mag    = w_b_neg ? -b_i : b_i;

   assign w_mul_add   = r_lo[0] ? r_mc : '0;
   assign w_mul_sum   = {1'b0, r_hi} + {1'b0, w_mul_add};
   assign w_div_shift = {r_hi, r_lo[XLEN-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_mc};

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg_res ? -w_prod : w_prod;

   // A zero divisor never borrows, so r_hi ends as |a| and the remainder falls out as a.
   always_comb begin
      w_md_res = '0;
      if (!r_op[2]) begin
         w_md_res = (r_op[1:0] == 2'd0) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
      end else if (!r_op[1]) begin
         w_md_res = r_div0 ? '1 : (r_neg_res ? -r_lo : r_lo);
      end else begin
         w_md_res = r_neg_a ? -r_hi : r_hi;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept_md) w_state_nxt = CALC;
         CALC:    if (r_count == LAST_STEP) w_state_nxt = FIX;
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept_md) begin
            r_count <= '0;
         end else if (r_state == CALC) begin
            r_count <= r_count + SHW'(1);
         end
      end
   end

   // NOTE: the iteration datapath has no reset; it is only read in CALC/FIX, which reset leaves.
   always_ff @(posedge clk) begin
      if (w_accept_md) begin
         r_op      <= md_op;
         r_neg_a   <= w_a_neg;
         r_neg_res <= w_a_neg ^ w_b_neg;
         r_div0    <= (b_i == '0);
         r_mc      <= w_b_mag;
         r_lo      <= w_a_mag;
         r_hi      <= '0;
         r_pc4     <= pc_address + XLEN'(4);
         r_pcimm   <= pc_address + imm;
      end else if (r_state == CALC) begin
         if (r_op[2]) begin
            if (!w_div_diff[XLEN]) begin
               r_hi <= w_div_diff[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
               r_hi <= w_div_shift[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
         end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
         end
      end
   end

   // An ALU accept and FIX never coincide: accepting requires IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_npc       <= '0;
         r_bt        <= '0;
      end else if (w_accept_alu) begin
         r_out_valid <= 1'b1;
         r_res       <= w_alu_res;
         r_npc       <= pc_address + XLEN'(4);
         r_bt        <= pc_address + imm;
      end else if (w_fix) begin
         r_out_valid <= 1'b1;
         r_res       <= w_md_res;
         r_npc       <= r_pc4;
         r_bt        <= r_pcimm;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
